rom_fetch_arbiter: RTL and testbench

- Shares the single combinational instruction ROM (8-bit address, 6-bit word) between two requesters: the CPU instruction fetch port and an internal dump engine that scans the program out over a debug port.
- Round-robin arbitration, one ROM access per cycle, fully pipelined with 2-cycle read latency.
- Sits between the CPU core, the ROM and the debug I/O mux.

---
 rtl/rom_fetch_arbiter.sv | 159 +++++++++++++++
 tb/tb_rom_fetch_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_arbiter.sv
// rtl/rom_fetch_arbiter.sv - round-robin sharing of the instruction ROM between CPU fetch and dump engine
// Two-stage read pipeline: address/owner capture, then data capture into the owner's port.
module rom_fetch_arbiter #(
  parameter int              AW        = 8,
  parameter int              DW        = 6,
  parameter logic [AW-1:0]   LAST_ADDR = 8'hFF,
  parameter logic [DW-1:0]   FILL      = 6'h3F
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_fill,
  input  logic          dump_start,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          dump_done,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_dump_q, last_dump_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_dump_q, s1_dump_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          cpu_fill_q, cpu_fill_d;
  logic          dump_valid_q, dump_valid_d;
  logic [AW-1:0] dump_addr_q, dump_addr_d;
  logic [DW-1:0] dump_data_q, dump_data_d;
  logic          dump_done_q, dump_done_d;

  logic dump_req;
  logic cpu_win;
  logic dump_win;

  // On a tie the port that did not win last time is served.
  assign dump_req = (state_q == S_RUN);
  assign cpu_win  = cpu_req && (!dump_req || last_dump_q);
  assign dump_win = dump_req && (!cpu_req || !last_dump_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_dump_d  = last_dump_q;
    rom_addr_d   = rom_addr_q;
    s1_valid_d   = cpu_win || dump_win;
    s1_dump_d    = dump_win;
    cpu_rvalid_d = s1_valid_q && !s1_dump_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_fill_d   = 1'b0;
    dump_valid_d = s1_valid_q && s1_dump_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    dump_done_d  = 1'b0;

    if (cpu_win) begin
      rom_addr_d  = cpu_addr;
      last_dump_d = 1'b0;
    end else if (dump_win) begin
      rom_addr_d  = cnt_q;
      last_dump_d = 1'b1;
    end

    if (cpu_rvalid_d) begin
      cpu_rdata_d = rom_data;
      cpu_fill_d  = (rom_data == FILL);
    end
    if (dump_valid_d) begin
      dump_addr_d = rom_addr_q;
      dump_data_d = rom_data;
    end

    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (dump_win) begin
          // Stop on the last address rather than incrementing, so an all-ones limit never wraps.
          if (cnt_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!(s1_valid_q && s1_dump_q)) begin
          dump_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_dump_q  <= 1'b1;
      rom_addr_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_dump_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_fill_q   <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_dump_q  <= last_dump_d;
      rom_addr_q   <= rom_addr_d;
      s1_valid_q   <= s1_valid_d;
      s1_dump_q    <= s1_dump_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_fill_q   <= cpu_fill_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      dump_done_q  <= dump_done_d;
    end
  end

  // Grant is combinational, so it is explicitly held low while reset is asserted.
  assign cpu_gnt    = cpu_win && !rst;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_fill   = cpu_fill_q;
  assign dump_busy  = (state_q != S_IDLE);
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_done  = dump_done_q;
  assign rom_addr   = rom_addr_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb/tb_rom_fetch_arbiter.sv - self-checking bench for rom_fetch_arbiter
// Second instance exercises the full 256-word scan.
module tb_rom_fetch_arbiter;

  localparam int LAST1 = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       cpu_req = 1'b0, cpu_gnt, cpu_rvalid, cpu_fill;
  logic [7:0] cpu_addr = 8'h00;
  logic [5:0] cpu_rdata;
  logic       dump_start = 1'b0, dump_busy, dump_valid, dump_done;
  logic [7:0] dump_addr, rom_addr;
  logic [5:0] dump_data, rom_data;

  logic       cpu_req_w = 1'b0, cpu_gnt_w, cpu_rvalid_w, cpu_fill_w;
  logic [7:0] cpu_addr_w = 8'h00;
  logic [5:0] cpu_rdata_w;
  logic       dump_start_w = 1'b0, dump_busy_w, dump_valid_w, dump_done_w;
  logic [7:0] dump_addr_w, rom_addr_w;
  logic [5:0] dump_data_w, rom_data_w;

  logic [5:0] rom_mem [256];
  logic [5:0] img [13];

  assign rom_data   = rom_mem[rom_addr];
  assign rom_data_w = rom_mem[rom_addr_w];

  rom_fetch_arbiter #(.AW(8), .DW(6), .LAST_ADDR(8'h0F), .FILL(6'h3F)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_fill(cpu_fill),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  rom_fetch_arbiter #(.AW(8), .DW(6), .LAST_ADDR(8'hFF), .FILL(6'h3F)) u_dut_w (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req_w), .cpu_addr(cpu_addr_w), .cpu_gnt(cpu_gnt_w),
    .cpu_rvalid(cpu_rvalid_w), .cpu_rdata(cpu_rdata_w), .cpu_fill(cpu_fill_w),
    .dump_start(dump_start_w), .dump_busy(dump_busy_w), .dump_valid(dump_valid_w),
    .dump_addr(dump_addr_w), .dump_data(dump_data_w), .dump_done(dump_done_w),
    .rom_addr(rom_addr_w), .rom_data(rom_data_w)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: events scheduled on a small cycle-indexed timeline.
  int         cyc = 0;
  bit         ev_cv [8];
  logic [5:0] ev_cd [8];
  bit         ev_dv [8];
  logic [7:0] ev_da [8];
  logic [5:0] ev_dd [8];
  bit         ev_done [8];
  bit         m_last_dump;
  int         m_to_issue;
  int         m_next;
  int         m_busy_until;
  bit         m_cpu_gnt = 1'b0;
  bit         o_dv, o_done, o_gnt;
  int         o_cyc;

  typedef struct {
    bit         req;
    logic [7:0] addr;
    bit         gnt;
    bit         rv;
    logic [5:0] rd;
    bit         fill;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 8; i++) begin
      ev_cv[i] = 0; ev_dv[i] = 0; ev_done[i] = 0;
      ev_cd[i] = '0; ev_da[i] = '0; ev_dd[i] = '0;
    end
    m_last_dump  = 1;
    m_to_issue   = 0;
    m_next       = 0;
    m_busy_until = -1;
    m_cpu_gnt    = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, cpu_gnt, 0);
    chk({tag, "_rvalid"}, cpu_rvalid, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_fill"}, cpu_fill, 0);
    chk({tag, "_busy"}, dump_busy, 0);
    chk({tag, "_dvalid"}, dump_valid, 0);
    chk({tag, "_daddr"}, dump_addr, 0);
    chk({tag, "_ddata"}, dump_data, 0);
    chk({tag, "_done"}, dump_done, 0);
    chk({tag, "_romaddr"}, rom_addr, 0);
  endtask

  task automatic do_reset();
    cpu_req = 0; dump_start = 0; dump_start_w = 0;
    rst = 1;
    #1;
    chk_zero("rst");
    chk("rst_busy_w", dump_busy_w, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    mreset();
  endtask

  // One cycle: inputs already applied by caller just after the falling edge.
  task automatic tick();
    int ci;
    bit dreq, dgnt, busy;
    #1;
    ci   = cyc % 8;
    dreq = (m_to_issue > 0);
    busy = dreq || (cyc <= m_busy_until);
    m_cpu_gnt = cpu_req && (!dreq || m_last_dump);
    dgnt = dreq && (!cpu_req || !m_last_dump);

    chk("cpu_gnt", cpu_gnt, m_cpu_gnt);
    chk("cpu_rvalid", cpu_rvalid, ev_cv[ci]);
    if (ev_cv[ci]) chk("cpu_rdata", cpu_rdata, ev_cd[ci]);
    chk("cpu_fill", cpu_fill, ev_cv[ci] && (ev_cd[ci] == 6'h3F));
    chk("dump_valid", dump_valid, ev_dv[ci]);
    if (ev_dv[ci]) begin
      chk("dump_addr", dump_addr, ev_da[ci]);
      chk("dump_data", dump_data, ev_dd[ci]);
    end
    chk("dump_done", dump_done, ev_done[ci]);
    chk("dump_busy", dump_busy, busy);
    o_dv = dump_valid; o_done = dump_done; o_gnt = cpu_gnt; o_cyc = cyc;

    ev_cv[ci] = 0; ev_dv[ci] = 0; ev_done[ci] = 0;
    if (m_cpu_gnt) begin
      ev_cv[(cyc + 2) % 8] = 1;
      ev_cd[(cyc + 2) % 8] = rom_mem[cpu_addr];
      m_last_dump = 0;
    end
    if (dgnt) begin
      ev_dv[(cyc + 2) % 8] = 1;
      ev_da[(cyc + 2) % 8] = 8'(m_next);
      ev_dd[(cyc + 2) % 8] = rom_mem[8'(m_next)];
      m_next++;
      m_to_issue--;
      if (m_to_issue == 0) begin
        m_busy_until = cyc + 2;
        ev_done[(cyc + 3) % 8] = 1;
      end
      m_last_dump = 1;
    end
    if (dump_start && !busy) begin
      m_to_issue = LAST1 + 1;
      m_next     = 0;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int beats, dones, last_beat, done_cyc, bad, extra;

    img = '{6'h10, 6'h28, 6'h11, 6'h29, 6'h12, 6'h2A, 6'h13, 6'h2B,
            6'h14, 6'h2C, 6'h3B, 6'h01, 6'h00};
    for (int a = 0; a < 256; a++) rom_mem[a] = 6'h3F;
    for (int a = 0; a < 13; a++) rom_mem[a] = img[a];
    for (int a = 8'h80; a < 8'hFF; a++) rom_mem[a] = 6'((a * 7) & 8'h3E);

    tbl[0]  = '{1, 8'h0A, 1, 0, 6'h00, 0};
    tbl[1]  = '{0, 8'h00, 0, 0, 6'h00, 0};
    tbl[2]  = '{0, 8'h00, 0, 1, 6'h3B, 0};
    tbl[3]  = '{0, 8'h00, 0, 0, 6'h00, 0};
    tbl[4]  = '{1, 8'h00, 1, 0, 6'h00, 0};
    tbl[5]  = '{1, 8'h01, 1, 0, 6'h00, 0};
    tbl[6]  = '{1, 8'h02, 1, 1, 6'h10, 0};
    tbl[7]  = '{1, 8'h03, 1, 1, 6'h28, 0};
    tbl[8]  = '{0, 8'h00, 0, 1, 6'h11, 0};
    tbl[9]  = '{1, 8'h40, 1, 1, 6'h29, 0};
    tbl[10] = '{0, 8'h00, 0, 0, 6'h00, 0};
    tbl[11] = '{0, 8'h00, 0, 1, 6'h3F, 1};
    tbl[12] = '{0, 8'h00, 0, 0, 6'h00, 0};

    mreset();
    do_reset();

    for (int i = 0; i < 13; i++) begin
      cpu_req  = tbl[i].req;
      cpu_addr = tbl[i].addr;
      #1;
      chk("tbl_gnt", cpu_gnt, tbl[i].gnt);
      chk("tbl_rvalid", cpu_rvalid, tbl[i].rv);
      if (tbl[i].rv) chk("tbl_rdata", cpu_rdata, tbl[i].rd);
      chk("tbl_fill", cpu_fill, tbl[i].fill);
      tick();
    end

    // Full 16-word scan with the CPU idle.
    cpu_req = 0;
    dump_start = 1;
    tick();
    dump_start = 0;
    beats = 0; dones = 0; last_beat = -10; done_cyc = -20;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_dv) begin beats++; last_beat = o_cyc; end
      if (o_done) begin dones++; done_cyc = o_cyc; end
    end
    chk("scan16_beats", beats, 16);
    chk("scan16_dones", dones, 1);
    chk("scan16_done_pos", done_cyc, last_beat + 1);
    chk("scan16_busy_after", dump_busy, 0);

    // Contention: CPU holds a request for the whole scan.
    do_reset();
    dump_start = 1;
    tick();
    dump_start = 0;
    cpu_req = 1;
    cpu_addr = 8'h05;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("alt_gnt", o_gnt, (i % 2) == 0);
    end
    cpu_req = 0;
    for (int i = 0; i < 10; i++) tick();

    // 256-word scan on the wide instance.
    dump_start_w = 1;
    @(posedge clk);
    @(negedge clk);
    dump_start_w = 0;
    beats = 0; dones = 0; bad = 0;
    for (int t = 0; t < 400 && dones == 0; t++) begin
      #1;
      if (dump_valid_w) begin
        if (dump_addr_w != 8'(beats) || dump_data_w != rom_mem[dump_addr_w]) bad++;
        beats++;
      end
      if (dump_done_w) dones = 1;
      @(posedge clk);
      @(negedge clk);
    end
    chk("scan256_done", dones, 1);
    chk("scan256_beats", beats, 256);
    chk("scan256_seq_errs", bad, 0);
    extra = 0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (dump_valid_w || dump_busy_w || dump_done_w) extra++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("scan256_no_restart", extra, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (!(cpu_req && !m_cpu_gnt)) begin
        cpu_req  = ($urandom_range(0, 9) < 6);
        cpu_addr = 8'($urandom_range(0, 255));
      end
      dump_start = ($urandom_range(0, 19) == 0);
      tick();
    end
    cpu_req = 0;
    dump_start = 0;
    for (int i = 0; i < 40; i++) tick();

    // Reset pulse inside a cycle with a CPU read and a scan in flight.
    dump_start = 1;
    tick();
    dump_start = 0;
    cpu_req = 1;
    cpu_addr = 8'h0A;
    tick();
    tick();
    cpu_req = 0;
    #1 rst = 1;
    #1 chk_zero("async");
    #1 rst = 0;
    mreset();
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_dv || o_done || cpu_rvalid) extra++;
    end
    chk("post_rst_stale", extra, 0);
    dump_start = 1;
    tick();
    dump_start = 0;
    beats = 0; dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_dv) beats++;
      if (o_done) dones++;
    end
    chk("fresh_scan_beats", beats, 16);
    chk("fresh_scan_dones", dones, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
